// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//
// Multicycle control FSM for the core. It walks each instruction through
// FETCH -> DECODE -> EXEC -> MEM -> WB. Memory accesses (instruction fetch,
// load, store) use a req/ack handshake that tolerates any number of wait
// states. An optional timeout sends the FSM to an absorbing error state.
// The EXEC length is configurable. run_i gates starting and continuing, and a
// retired-instruction counter is provided.
//
// Instruction type codes on itype_i:
//   R=1 I=2 S=3 B=4 U=5 L=6 UPC=7 HOLD=8. Every other value is unknown and
//   runs as a nop: no operand pulses and no write-back, but it still retires
//   and advances the PC.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   run_i                 level: leave IDLE / continue after WB
//   stage_o               state: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 ERR=7
//   mem_req_o/we/addr/wdata  memory request port; held until mem_ack_i
//   mem_rdata_i/mem_ack_i memory response; ack ignored while mem_req_o=0
//   pc_i, pc_readin_o     current PC; PC-advance pulse (WB)
//   ir_o                  instruction register (loaded on fetch ack)
//   itype_i               decoded type of ir_o
//   alu_result_i          effective address for loads/stores
//   store_data_i          store data
//   load_data_o           latched load data (loaded on load ack)
//   readin_a/b/pass_o     ALU operand latch pulses (first EXEC cycle)
//   wd_q_readin_o         write-back data capture pulse (last MEM cycle)
//   wd_q_o                register-file write pulse (WB)
//   halted_o, timeout_o   HALT indicator; sticky memory-timeout flag
//   instret_o             retired instructions, wraps
//
// Control outputs are decoded from the state register and the itype
// register, so they change only on clock edges (or on reset). There are two
// exceptions:
// - The address and data buses pass pc_i, alu_result_i and store_data_i
//   straight through while a request is active. Those inputs only settle
//   in the cycle the request starts.
// - For loads, the last MEM cycle is the cycle of the ack itself, so
//   wd_q_readin_o follows mem_ack_i in that case.
module multicycle_sequencer #(
  parameter int XLEN        = 32,
  parameter int ITYPE_W     = 5,
  parameter int EXEC_CYCLES = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_i,
  output logic [2:0]         stage_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [XLEN-1:0]    mem_addr_o,
  output logic [XLEN-1:0]    mem_wdata_o,
  input  logic [XLEN-1:0]    mem_rdata_i,
  input  logic               mem_ack_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               pc_readin_o,
  output logic [XLEN-1:0]    ir_o,
  input  logic [ITYPE_W-1:0] itype_i,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic [XLEN-1:0]    store_data_i,
  output logic [XLEN-1:0]    load_data_o,
  output logic               readin_a_o,
  output logic               readin_b_o,
  output logic               readin_pass_o,
  output logic               wd_q_readin_o,
  output logic               wd_q_o,
  output logic               halted_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   instret_o
);

  localparam logic [ITYPE_W-1:0] IT_R    = ITYPE_W'(1);
  localparam logic [ITYPE_W-1:0] IT_I    = ITYPE_W'(2);
  localparam logic [ITYPE_W-1:0] IT_S    = ITYPE_W'(3);
  localparam logic [ITYPE_W-1:0] IT_B    = ITYPE_W'(4);
  localparam logic [ITYPE_W-1:0] IT_U    = ITYPE_W'(5);
  localparam logic [ITYPE_W-1:0] IT_L    = ITYPE_W'(6);
  localparam logic [ITYPE_W-1:0] IT_UPC  = ITYPE_W'(7);
  localparam logic [ITYPE_W-1:0] IT_HOLD = ITYPE_W'(8);

  localparam int EX_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [EX_W-1:0] EX_LAST = EX_W'((EXEC_CYCLES > 1) ? EXEC_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 1) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t             state, state_nxt;
  logic [ITYPE_W-1:0] itype_q;
  logic [EX_W-1:0]    exec_cnt;
  logic [TO_W-1:0]    wait_cnt;
  logic               rd_a_q, rd_b_q, rd_p_q;
  logic               rd_a_nxt, rd_b_nxt, rd_p_nxt;
  logic               timeout_q;
  logic [XLEN-1:0]    ir_q, load_q;
  logic [CNT_W-1:0]   instret_q;

  logic q_load, q_store, q_wb, mem_busy, req, timed_out;

  // itype_q holds the type latched in DECODE; MEM and WB act on it.
  assign q_load    = (itype_q == IT_L);
  assign q_store   = (itype_q == IT_S);
  assign q_wb      = (itype_q == IT_R) || (itype_q == IT_I) || (itype_q == IT_U) ||
                     (itype_q == IT_L) || (itype_q == IT_UPC);
  assign mem_busy  = (state == S_MEM) && (q_load || q_store);
  assign req       = (state == S_FETCH) || mem_busy;
  // wait_cnt has already counted TO_LAST unacknowledged cycles, so this
  // cycle is the MEM_TIMEOUT-th one.
  assign timed_out = (MEM_TIMEOUT > 0) && req && !mem_ack_i && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_a_nxt  = 1'b0;
    rd_b_nxt  = 1'b0;
    rd_p_nxt  = 1'b0;
    case (state)
      S_IDLE: if (run_i) state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack_i)      state_nxt = S_DECODE;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_DECODE: begin
        if (itype_i == IT_HOLD) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
          case (itype_i)
            IT_R, IT_I, IT_L: begin
              rd_a_nxt = 1'b1;
              rd_b_nxt = 1'b1;
            end
            IT_S, IT_B: begin
              rd_a_nxt = 1'b1;
              rd_b_nxt = 1'b1;
              rd_p_nxt = 1'b1;
            end
            IT_U:    rd_a_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      S_EXEC: if (exec_cnt == EX_LAST) state_nxt = S_MEM;
      S_MEM: begin
        if (!mem_busy || mem_ack_i) state_nxt = S_WB;
        else if (timed_out)         state_nxt = S_ERR;
      end
      S_WB:    state_nxt = run_i ? S_FETCH : S_IDLE;
      default: ;  // HALT and ERR are left only through reset
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      itype_q   <= '0;
      exec_cnt  <= '0;
      wait_cnt  <= '0;
      rd_a_q    <= 1'b0;
      rd_b_q    <= 1'b0;
      rd_p_q    <= 1'b0;
      timeout_q <= 1'b0;
      ir_q      <= '0;
      load_q    <= '0;
      instret_q <= '0;
    end else begin
      rd_a_q <= rd_a_nxt;
      rd_b_q <= rd_b_nxt;
      rd_p_q <= rd_p_nxt;
      if (state == S_DECODE) itype_q <= itype_i;
      exec_cnt <= ((state == S_EXEC) && (state_nxt == S_EXEC)) ? exec_cnt + 1'b1 : '0;
      // While a request stays in its state, no ack has arrived and no timeout
      // has fired, so this counts only unacknowledged request cycles.
      wait_cnt <= (req && (state_nxt == state)) ? wait_cnt + 1'b1 : '0;
      if ((state == S_FETCH) && mem_ack_i)   ir_q      <= mem_rdata_i;
      if (mem_busy && q_load && mem_ack_i)   load_q    <= mem_rdata_i;
      if (state == S_WB)                     instret_q <= instret_q + 1'b1;
      if (timed_out)                         timeout_q <= 1'b1;
    end
  end

  assign stage_o       = state;
  assign mem_req_o     = req;
  assign mem_we_o      = mem_busy && q_store;
  assign mem_addr_o    = (state == S_FETCH) ? pc_i : (mem_busy ? alu_result_i : '0);
  assign mem_wdata_o   = (mem_busy && q_store) ? store_data_i : '0;
  assign ir_o          = ir_q;
  assign load_data_o   = load_q;
  assign readin_a_o    = rd_a_q;
  assign readin_b_o    = rd_b_q;
  assign readin_pass_o = rd_p_q;
  // A load's final MEM cycle is its ack cycle; other types spend one cycle in MEM.
  assign wd_q_readin_o = (state == S_MEM) && q_wb && (!q_load || mem_ack_i);
  assign wd_q_o        = (state == S_WB) && q_wb;
  assign pc_readin_o   = (state == S_WB);
  assign halted_o      = (state == S_HALT);
  assign timeout_o     = timeout_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int EXEC = 1;

  localparam logic [4:0] IT_R = 5'd1, IT_I = 5'd2, IT_S = 5'd3, IT_B = 5'd4;
  localparam logic [4:0] IT_U = 5'd5, IT_L = 5'd6, IT_UPC = 5'd7, IT_HOLD = 5'd8;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_ERR = 3'd7;

  // flag bits: req we a b pass wqr wq pcr hlt tmo
  localparam logic [9:0] Z     = 10'b0000000000;
  localparam logic [9:0] F_REQ = 10'b1000000000;
  localparam logic [9:0] F_WE  = 10'b0100000000;
  localparam logic [9:0] F_A   = 10'b0010000000;
  localparam logic [9:0] F_B   = 10'b0001000000;
  localparam logic [9:0] F_P   = 10'b0000100000;
  localparam logic [9:0] F_WQR = 10'b0000010000;
  localparam logic [9:0] F_WQ  = 10'b0000001000;
  localparam logic [9:0] F_PCR = 10'b0000000100;
  localparam logic [9:0] F_HLT = 10'b0000000010;
  localparam logic [9:0] F_TMO = 10'b0000000001;

  localparam logic [31:0] PC0 = 32'h0000_0100, ALU0 = 32'h0000_0040, SD0 = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [2:0] stage;
    logic req, we, ra, rb, rp, wqr, wq, pcr, hlt, tmo;
  } obs_t;

  typedef struct {
    logic        run, ack;
    logic [4:0]  ity;
    logic [31:0] rdata, pc, alu, sd;
    obs_t        obs;
    logic        chk;
    logic [31:0] ir, ld, ret;
  } vec_t;

  logic        clk = 1'b0, reset = 1'b1, run_i = 1'b0, mem_ack_i = 1'b0;
  logic [2:0]  stage_o;
  logic        mem_req_o, mem_we_o, pc_readin_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ir_o, load_data_o, instret_o;
  logic [31:0] mem_rdata_i = '0, pc_i = '0, alu_result_i = '0, store_data_i = '0;
  logic [4:0]  itype_i = '0;
  logic        readin_a_o, readin_b_o, readin_pass_o, wd_q_readin_o, wd_q_o, halted_o, timeout_o;

  int n_tests = 0, n_fail = 0;
  vec_t dir[$];
  vec_t rq[$];
  logic [31:0] m_ir, m_ld, m_ret;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .XLEN(32), .ITYPE_W(5), .EXEC_CYCLES(EXEC), .MEM_TIMEOUT(16), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .stage_o(stage_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_i(pc_i), .pc_readin_o(pc_readin_o), .ir_o(ir_o), .itype_i(itype_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .load_data_o(load_data_o),
    .readin_a_o(readin_a_o), .readin_b_o(readin_b_o), .readin_pass_o(readin_pass_o),
    .wd_q_readin_o(wd_q_readin_o), .wd_q_o(wd_q_o), .halted_o(halted_o),
    .timeout_o(timeout_o), .instret_o(instret_o)
  );

  function automatic obs_t got_obs();
    return {stage_o, mem_req_o, mem_we_o, readin_a_o, readin_b_o, readin_pass_o,
            wd_q_readin_o, wd_q_o, pc_readin_o, halted_o, timeout_o};
  endfunction

  function automatic obs_t ob(input logic [2:0] st, input logic [9:0] f);
    return {st, f};
  endfunction

  function automatic vec_t mkv(input logic run, input logic ack, input logic [4:0] ity,
                               input logic [31:0] rdata, input obs_t o);
    vec_t v;
    v.run = run; v.ack = ack; v.ity = ity; v.rdata = rdata;
    v.pc = PC0; v.alu = ALU0; v.sd = SD0; v.obs = o;
    v.chk = 1'b0; v.ir = '0; v.ld = '0; v.ret = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive the record's inputs, then compare at the falling edge.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk); #1;
    run_i = v.run; mem_ack_i = v.ack; itype_i = v.ity; mem_rdata_i = v.rdata;
    pc_i = v.pc; alu_result_i = v.alu; store_data_i = v.sd;
    @(negedge clk);
    chk({tag, " ctl"}, 32'(got_obs()), 32'(v.obs));
    if (v.obs.req) chk({tag, " addr"}, mem_addr_o, (v.obs.stage == ST_FETCH) ? v.pc : v.alu);
    if (v.obs.we)  chk({tag, " wdata"}, mem_wdata_o, v.sd);
    if (v.chk) begin
      chk({tag, " ir"}, ir_o, v.ir);
      chk({tag, " load"}, load_data_o, v.ld);
      chk({tag, " instret"}, instret_o, v.ret);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; run_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    chk("reset ctl", 32'(got_obs()), 32'(0));
    chk("reset ir", ir_o, 32'h0);
    chk("reset load", load_data_o, 32'h0);
    chk("reset instret", instret_o, 32'h0);
    chk("reset addr", mem_addr_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic run, input logic ack, input logic [4:0] ity, input logic [31:0] rdata,
                      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd, input obs_t o);
    vec_t v;
    v.run = run; v.ack = ack; v.ity = ity; v.rdata = rdata;
    v.pc = pc; v.alu = alu; v.sd = sd; v.obs = o;
    v.chk = 1'b1; v.ir = m_ir; v.ld = m_ld; v.ret = m_ret;
    rq.push_back(v);
  endtask

  // Reference model: expands one instruction into its expected cycle trace
  // from the stage rules (lengths, per-type pulses, data capture points).
  task automatic gen_instr(input logic [4:0] ity, input int fw, input int mw, input logic last);
    logic [31:0] pc, alu, sd, word, ldw;
    logic        is_l, is_s, memop, wb;
    logic [9:0]  rd, f;
    int          nmem;
    pc = $urandom; alu = $urandom; sd = $urandom; word = $urandom; ldw = $urandom;
    is_l  = (ity == IT_L);
    is_s  = (ity == IT_S);
    memop = is_l || is_s;
    wb    = (ity == IT_R) || (ity == IT_I) || (ity == IT_U) || (ity == IT_L) || (ity == IT_UPC);
    if ((ity == IT_R) || (ity == IT_I) || (ity == IT_L)) rd = F_A | F_B;
    else if ((ity == IT_S) || (ity == IT_B))             rd = F_A | F_B | F_P;
    else if (ity == IT_U)                                rd = F_A;
    else                                                 rd = Z;
    nmem = memop ? mw + 1 : 1;
    for (int i = 0; i <= fw; i++)
      push(1'b1, i == fw, ity, (i == fw) ? word : $urandom, pc, alu, sd, ob(ST_FETCH, F_REQ));
    m_ir = word;
    push(1'b1, 1'($urandom), ity, $urandom, pc, alu, sd, ob(ST_DEC, Z));
    for (int e = 0; e < EXEC; e++)
      push(1'b1, 1'($urandom), ity, $urandom, pc, alu, sd, ob(ST_EXEC, (e == 0) ? rd : Z));
    for (int i = 0; i < nmem; i++) begin
      f = Z;
      if (memop) f = f | F_REQ;
      if (is_s) f = f | F_WE;
      if (wb && (i == nmem - 1)) f = f | F_WQR;
      push(1'b1, memop ? (i == nmem - 1) : 1'($urandom), ity,
           (is_l && (i == nmem - 1)) ? ldw : $urandom, pc, alu, sd, ob(ST_MEM, f));
    end
    if (is_l) m_ld = ldw;
    push(!last, 1'($urandom), ity, $urandom, pc, alu, sd, ob(ST_WB, (wb ? F_WQ : Z) | F_PCR));
    m_ret = m_ret + 32'd1;
  endtask

  initial begin
    logic [4:0] types [9];
    types = '{IT_R, IT_I, IT_S, IT_B, IT_U, IT_L, IT_UPC, 5'd0, 5'd20};

    // Directed table: R-type zero-wait, then store with 3 fetch wait states.
    dir.push_back(mkv(1'b1, 1'b0, IT_R, 32'h0,         ob(ST_IDLE, Z)));
    dir.push_back(mkv(1'b1, 1'b1, IT_R, 32'h0033_00B3, ob(ST_FETCH, F_REQ)));
    dir.push_back(mkv(1'b1, 1'b0, IT_R, 32'h0,         ob(ST_DEC, Z)));
    dir.push_back(mkv(1'b1, 1'b0, IT_R, 32'h0,         ob(ST_EXEC, F_A | F_B)));
    dir.push_back(mkv(1'b1, 1'b0, IT_R, 32'h0,         ob(ST_MEM, F_WQR)));
    dir.push_back(mkv(1'b1, 1'b0, IT_R, 32'h0,         ob(ST_WB, F_WQ | F_PCR)));
    dir.push_back(mkv(1'b1, 1'b0, IT_S, 32'h1111_1111, ob(ST_FETCH, F_REQ)));
    dir.push_back(mkv(1'b1, 1'b0, IT_S, 32'h2222_2222, ob(ST_FETCH, F_REQ)));
    dir.push_back(mkv(1'b1, 1'b0, IT_S, 32'h3333_3333, ob(ST_FETCH, F_REQ)));
    dir.push_back(mkv(1'b1, 1'b1, IT_S, 32'h0400_2023, ob(ST_FETCH, F_REQ)));
    dir.push_back(mkv(1'b1, 1'b0, IT_S, 32'h0,         ob(ST_DEC, Z)));
    dir.push_back(mkv(1'b1, 1'b0, IT_S, 32'h0,         ob(ST_EXEC, F_A | F_B | F_P)));
    dir.push_back(mkv(1'b1, 1'b0, IT_S, 32'h0,         ob(ST_MEM, F_REQ | F_WE)));
    dir.push_back(mkv(1'b1, 1'b1, IT_S, 32'h0,         ob(ST_MEM, F_REQ | F_WE)));
    dir.push_back(mkv(1'b0, 1'b0, IT_S, 32'h0,         ob(ST_WB, F_PCR)));
    dir.push_back(mkv(1'b0, 1'b0, IT_S, 32'h0,         ob(ST_IDLE, Z)));

    repeat (2) @(posedge clk);
    reset_dut();
    for (int i = 0; i < dir.size(); i++) begin
      apply(dir[i], $sformatf("dir[%0d]", i));
      if (i == 5) chk("instret before WB edge", instret_o, 32'd0);
      if (i == 6) chk("instret after WB edge", instret_o, 32'd1);
      if (i == 2) chk("ir after zero-wait fetch", ir_o, 32'h0033_00B3);
    end
    chk("dir ir store", ir_o, 32'h0400_2023);
    chk("dir instret", instret_o, 32'd2);

    // Fetch timeout: 16 unacknowledged request cycles, then ERR until reset.
    reset_dut();
    apply(mkv(1'b1, 1'b0, IT_R, 32'h0, ob(ST_IDLE, Z)), "fto idle");
    for (int i = 0; i < 16; i++) apply(mkv(1'b1, 1'b0, IT_R, $urandom, ob(ST_FETCH, F_REQ)), "fto wait");
    for (int i = 0; i < 8; i++)  apply(mkv(1'b1, 1'($urandom), IT_R, $urandom, ob(ST_ERR, F_TMO)), "fto err");
    chk("fto ir untouched", ir_o, 32'h0);
    reset_dut();
    chk("fto cleared", 32'(timeout_o), 32'd0);

    // Load timeout in MEM follows the same rule.
    apply(mkv(1'b1, 1'b0, IT_L, 32'h0,         ob(ST_IDLE, Z)), "mto idle");
    apply(mkv(1'b1, 1'b1, IT_L, 32'h0001_2083, ob(ST_FETCH, F_REQ)), "mto fetch");
    apply(mkv(1'b1, 1'b0, IT_L, 32'h0,         ob(ST_DEC, Z)), "mto dec");
    apply(mkv(1'b1, 1'b0, IT_L, 32'h0,         ob(ST_EXEC, F_A | F_B)), "mto exec");
    for (int i = 0; i < 16; i++) apply(mkv(1'b1, 1'b0, IT_L, $urandom, ob(ST_MEM, F_REQ)), "mto wait");
    for (int i = 0; i < 4; i++)  apply(mkv(1'b1, 1'($urandom), IT_L, $urandom, ob(ST_ERR, F_TMO)), "mto err");
    chk("mto load untouched", load_data_o, 32'h0);
    chk("mto instret", instret_o, 32'h0);

    // HOLD: HALT absorbs, no requests or pulses for 50 cycles.
    reset_dut();
    apply(mkv(1'b1, 1'b0, IT_HOLD, 32'h0,         ob(ST_IDLE, Z)), "hold idle");
    apply(mkv(1'b1, 1'b1, IT_HOLD, 32'h0000_0073, ob(ST_FETCH, F_REQ)), "hold fetch");
    apply(mkv(1'b1, 1'b0, IT_HOLD, 32'h0,         ob(ST_DEC, Z)), "hold dec");
    for (int i = 0; i < 50; i++) apply(mkv(1'b1, 1'($urandom), IT_HOLD, $urandom, ob(ST_HALT, F_HLT)), "halt");
    chk("halt instret", instret_o, 32'h0);

    // Asynchronous reset in the middle of a load request.
    reset_dut();
    apply(mkv(1'b1, 1'b0, IT_L, 32'h0,         ob(ST_IDLE, Z)), "rst idle");
    apply(mkv(1'b1, 1'b1, IT_L, 32'hCAFE_0003, ob(ST_FETCH, F_REQ)), "rst fetch");
    apply(mkv(1'b1, 1'b0, IT_L, 32'h0,         ob(ST_DEC, Z)), "rst dec");
    apply(mkv(1'b1, 1'b0, IT_L, 32'h0,         ob(ST_EXEC, F_A | F_B)), "rst exec");
    apply(mkv(1'b1, 1'b0, IT_L, 32'h0,         ob(ST_MEM, F_REQ)), "rst mem");
    #1 reset = 1'b1;
    #1;
    chk("async rst req", 32'(mem_req_o), 32'd0);
    chk("async rst ctl", 32'(got_obs()), 32'd0);
    chk("async rst ir", ir_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; run_i = 1'b0;
    @(negedge clk);
    chk("after rst stage", 32'(stage_o), 32'(ST_IDLE));

    // Randomized back-to-back instructions against the trace model.
    reset_dut();
    m_ir = '0; m_ld = '0; m_ret = '0;
    push(1'b1, 1'b0, IT_R, 32'h0, PC0, ALU0, SD0, ob(ST_IDLE, Z));
    for (int n = 0; n < 60; n++)
      gen_instr(types[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 5), n == 59);
    push(1'b0, 1'b0, IT_R, 32'h0, PC0, ALU0, SD0, ob(ST_IDLE, Z));
    for (int i = 0; i < rq.size(); i++) apply(rq[i], $sformatf("rnd[%0d]", i));
    chk("rnd instret total", instret_o, 32'd60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
